// File: rtl/ppu_timing_pkg.sv
// Shared frame-timing constants, region encoding and position typedef for the
// PPU frame timer and its divider.
package ppu_timing_pkg;

  localparam int DEF_DIV_NTSC      = 4;
  localparam int DEF_DIV_PAL       = 5;
  localparam int DEF_DOTS_PER_LINE = 341;
  localparam int DEF_LINES_NTSC    = 262;
  localparam int DEF_LINES_PAL     = 312;
  localparam int DEF_VBLANK_LINE   = 241;
  localparam int DEF_CNT_W         = 9;

  typedef enum logic {
    REGION_NTSC = 1'b0,
    REGION_PAL  = 1'b1
  } region_e;

  typedef struct packed {
    logic [DEF_CNT_W-1:0] line;
    logic [DEF_CNT_W-1:0] dot;
  } dot_line_t;

endpackage

// File: rtl/ppu_dot_divider.sv
// Master-clock divider: emits one dot_ce per DIV_NTSC or DIV_PAL clocks,
// the modulus chosen by the latched region.
module ppu_dot_divider #(
  parameter int DIV_NTSC = 4,
  parameter int DIV_PAL  = 5
) (
  input  logic CLK,
  input  logic RST,
  input  logic region_q,
  output logic dot_ce
);

  localparam int DIV_MAX = (DIV_NTSC > DIV_PAL) ? DIV_NTSC : DIV_PAL;
  localparam int DIV_W   = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [DIV_W-1:0] TOP_NTSC = DIV_W'(DIV_NTSC - 1);
  localparam logic [DIV_W-1:0] TOP_PAL  = DIV_W'(DIV_PAL - 1);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] countTop;

  // region_q only changes on the dot_ce that wraps the frame, when count
  // is returning to 0, so the modulus switch never truncates a dot.
  assign countTop = region_q ? TOP_PAL : TOP_NTSC;
  assign dot_ce   = (count == countTop);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count <= '0;
    end else if (dot_ce) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/ppu_frame_timer.sv
// PPU frame timer: dot/scanline counters, vblank/NMI generation, odd-frame
// dot skip and runtime NTSC/PAL geometry selection.
module ppu_frame_timer
  import ppu_timing_pkg::*;
#(
  parameter int DIV_NTSC      = DEF_DIV_NTSC,
  parameter int DIV_PAL       = DEF_DIV_PAL,
  parameter int DOTS_PER_LINE = DEF_DOTS_PER_LINE,
  parameter int LINES_NTSC    = DEF_LINES_NTSC,
  parameter int LINES_PAL     = DEF_LINES_PAL,
  parameter int VBLANK_LINE   = DEF_VBLANK_LINE,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             region_pal,
  input  logic             render_en,
  input  logic             nmi_en,
  input  logic             status_rd,
  output logic             dot_ce,
  output logic [CNT_W-1:0] dot,
  output logic [CNT_W-1:0] line,
  output logic             visible,
  output logic             prerender,
  output logic             vblank,
  output logic             set_vblank,
  output logic             clear_vblank,
  output logic             nmi_n,
  output logic             frame_odd,
  output logic             region_q
);

  localparam logic [CNT_W-1:0] DOT_LAST   = CNT_W'(DOTS_PER_LINE - 1);
  localparam logic [CNT_W-1:0] DOT_SKIP   = CNT_W'(DOTS_PER_LINE - 2);
  localparam logic [CNT_W-1:0] LAST_NTSC  = CNT_W'(LINES_NTSC - 1);
  localparam logic [CNT_W-1:0] LAST_PAL   = CNT_W'(LINES_PAL - 1);
  localparam logic [CNT_W-1:0] VBL_LINE   = CNT_W'(VBLANK_LINE);
  // The post-render line sits just before the vblank line; everything
  // above it is visible (240 with the default geometry).
  localparam logic [CNT_W-1:0] POST_LINE  = CNT_W'(VBLANK_LINE - 1);

  region_e          regionQ;
  logic [CNT_W-1:0] lastLine;
  logic             atLastLine;
  logic             atLastDot;
  logic             skipDot;
  logic             atSetPoint;
  logic             raceSeen;

  ppu_dot_divider #(
    .DIV_NTSC (DIV_NTSC),
    .DIV_PAL  (DIV_PAL)
  ) u_divider (
    .CLK      (CLK),
    .RST      (RST),
    .region_q (region_q),
    .dot_ce   (dot_ce)
  );

  always_comb begin
    lastLine     = (regionQ == REGION_PAL) ? LAST_PAL : LAST_NTSC;
    atLastLine   = (line == lastLine);
    atLastDot    = (dot == DOT_LAST);
    skipDot      = (regionQ == REGION_NTSC) && render_en && frame_odd &&
                   atLastLine && (dot == DOT_SKIP);
    atSetPoint   = (line == VBL_LINE) && (dot == '0);
    // A status read anywhere in the set dot period (including its dot_ce
    // clock) cancels this frame's vblank set.
    set_vblank   = dot_ce && atSetPoint && !(raceSeen || status_rd);
    clear_vblank = dot_ce && atLastLine && (dot == '0);
  end

  assign region_q  = (regionQ == REGION_PAL);
  assign visible   = (line < POST_LINE);
  assign prerender = atLastLine;
  assign nmi_n     = !(vblank && nmi_en);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      dot       <= '0;
      line      <= '0;
      frame_odd <= 1'b0;
      regionQ   <= REGION_NTSC;
      vblank    <= 1'b0;
      raceSeen  <= 1'b0;
    end else begin
      if (dot_ce) begin
        if (atLastDot || skipDot) begin
          dot <= '0;
          if (atLastLine) begin
            line      <= '0;
            frame_odd <= ~frame_odd;
            regionQ   <= region_e'(region_pal);
          end else begin
            line <= line + CNT_W'(1);
          end
        end else begin
          dot <= dot + CNT_W'(1);
        end
      end

      if (dot_ce && atSetPoint) begin
        raceSeen <= 1'b0;
      end else if (status_rd && atSetPoint) begin
        raceSeen <= 1'b1;
      end

      if (clear_vblank || status_rd) begin
        vblank <= 1'b0;
      end else if (set_vblank) begin
        vblank <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ppu_frame_timer.sv
// Randomized bench for ppu_frame_timer on a reduced geometry, checked per
// clock against a frame-position model and per frame against length rules.
module tb_ppu_frame_timer;

  localparam int DN    = 4;
  localparam int DP    = 5;
  localparam int DOTS  = 24;
  localparam int LN    = 10;
  localparam int LP    = 12;
  localparam int VB    = 7;
  localparam int CW    = 9;
  localparam int NCYC  = 40000;

  logic          CLK;
  logic          RST;
  logic          region_pal;
  logic          render_en;
  logic          nmi_en;
  logic          status_rd;
  logic          dot_ce;
  logic [CW-1:0] dot;
  logic [CW-1:0] line;
  logic          visible;
  logic          prerender;
  logic          vblank;
  logic          set_vblank;
  logic          clear_vblank;
  logic          nmi_n;
  logic          frame_odd;
  logic          region_q;

  ppu_frame_timer #(
    .DIV_NTSC      (DN),
    .DIV_PAL       (DP),
    .DOTS_PER_LINE (DOTS),
    .LINES_NTSC    (LN),
    .LINES_PAL     (LP),
    .VBLANK_LINE   (VB),
    .CNT_W         (CW)
  ) dut (
    .CLK          (CLK),
    .RST          (RST),
    .region_pal   (region_pal),
    .render_en    (render_en),
    .nmi_en       (nmi_en),
    .status_rd    (status_rd),
    .dot_ce       (dot_ce),
    .dot          (dot),
    .line         (line),
    .visible      (visible),
    .prerender    (prerender),
    .vblank       (vblank),
    .set_vblank   (set_vblank),
    .clear_vblank (clear_vblank),
    .nmi_n        (nmi_n),
    .frame_odd    (frame_odd),
    .region_q     (region_q)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 25)
        $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: frame position as a linear dot index
  int m_div, m_pos, m_odd, m_region, m_vbl, m_race;

  function automatic void model_reset();
    m_div = 0; m_pos = 0; m_odd = 0; m_region = 0; m_vbl = 0; m_race = 0;
  endfunction

  // frame-length scoreboard, derived independently from the frame rules
  logic [31:0] exp_q[$];
  int  have_start, f_odd, f_region, f_count, ce_cnt, clk_cnt;
  int  prev_dot, prev_line;
  logic prev_region_pal;

  function automatic void frame_reset();
    have_start = 0; f_odd = 0; f_region = 0; ce_cnt = 0; clk_cnt = 0;
    prev_dot = 0; prev_line = 0;
  endfunction

  initial begin
    int  lines, divn, m_dot, m_line, ce, at_set, e_set, e_clr, flen;
    bit  boundary;
    RST = 1'b0; region_pal = 1'b0; render_en = 1'b1; nmi_en = 1'b1; status_rd = 1'b0;
    prev_region_pal = 1'b0;
    f_count = 0;
    model_reset();
    frame_reset();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge CLK);
      m_dot  = m_pos % DOTS;
      m_line = m_pos / DOTS;
      // driver
      RST = !((cyc < 5) || (cyc >= 20000 && cyc < 20006));
      status_rd = 1'b0;
      if (RST) begin
        if (m_line == VB && m_dot == 0 && m_div == 1 && (f_count % 3) == 1)
          status_rd = 1'b1;
        else if ($urandom_range(0, 199) == 0)
          status_rd = 1'b1;
        if ($urandom_range(0, 99) == 0) nmi_en = ~nmi_en;
        if (m_line == 1 && m_dot == 0 && m_div == 0)
          render_en = ($urandom_range(0, 3) != 0);
        if (m_line == 3 && m_dot == 5 && m_div == 0 && $urandom_range(0, 3) == 0)
          region_pal = ~region_pal;
      end
      #1;
      if (!RST) begin
        model_reset();
        frame_reset();
        m_dot = 0; m_line = 0;
      end

      lines  = m_region ? LP : LN;
      divn   = m_region ? DP : DN;
      ce     = (m_div == divn - 1);
      at_set = (m_line == VB && m_dot == 0);
      e_set  = ce && at_set && !(m_race || status_rd);
      e_clr  = ce && (m_line == lines - 1) && (m_dot == 0);

      check("dot_ce",       dot_ce,       ce);
      check("dot",          dot,          m_dot);
      check("line",         line,         m_line);
      check("vblank",       vblank,       m_vbl);
      check("nmi_n",        nmi_n,        !(m_vbl && nmi_en));
      check("set_vblank",   set_vblank,   e_set);
      check("clear_vblank", clear_vblank, e_clr);
      check("frame_odd",    frame_odd,    m_odd);
      check("region_q",     region_q,     m_region);
      check("visible",      visible,      (m_line < VB - 1));
      check("prerender",    prerender,    (m_line == lines - 1));

      // frame length from the DUT's own line-0 dot-0 events
      if (RST) begin
        boundary = (dot == 0 && line == 0) && !(prev_dot == 0 && prev_line == 0);
        if (boundary) begin
          flen = DOTS * (f_region ? LP : LN) - ((!f_region && render_en && f_odd) ? 1 : 0);
          if (have_start) begin
            exp_q.push_back(flen);
            check("frame_dots", ce_cnt, exp_q.pop_front());
            check("frame_clks", clk_cnt, flen * (f_region ? DP : DN));
          end
          have_start = 1;
          f_odd = f_odd ^ 1;
          f_region = prev_region_pal;
          f_count++;
          ce_cnt = 0;
          clk_cnt = 0;
        end
        clk_cnt++;
        if (dot_ce) ce_cnt++;
        prev_dot = dot;
        prev_line = line;
        prev_region_pal = region_pal;
      end

      // model advance to the next clock edge
      if (RST) begin
        if (at_set && ce)             m_race = 0;
        else if (at_set && status_rd) m_race = 1;
        if (e_clr || status_rd) m_vbl = 0;
        else if (e_set)         m_vbl = 1;
        if (ce) begin
          m_div = 0;
          if ((m_pos == lines * DOTS - 1) ||
              (!m_region && render_en && m_odd && m_pos == lines * DOTS - 2)) begin
            m_pos = 0;
            m_odd = m_odd ^ 1;
            m_region = region_pal;
          end else begin
            m_pos++;
          end
        end else begin
          m_div++;
        end
      end
    end

    if (f_count < 10) check("frames_seen", f_count, 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ppu_frame_timer.md
# ppu_frame_timer

Parametrised frame-timing core for the PPU: it divides the master clock into a dot clock enable and runs the dot/scanline counters. It also generates the vertical-blank flag, the NMI, the odd-frame dot skip and the visible/pre-render qualifiers, and selects NTSC or PAL geometry at runtime. It sits between the master clock and the render, register and sprite logic, replacing the fixed divide-by-4 enable and the hard-wired 262-line frame.

## Interface
Parameters:
- DIV_NTSC, 4, master clocks per dot in NTSC mode
- DIV_PAL, 5, master clocks per dot in PAL mode
- DOTS_PER_LINE, 341, dots per scanline (0..340)
- LINES_NTSC, 262, scanlines per NTSC frame
- LINES_PAL, 312, scanlines per PAL frame
- VBLANK_LINE, 241, scanline on which vblank is set (both modes)
- CNT_W, 9, dot/line counter width

Ports:
- CLK  in  1  master clock
- RST  in  1  reset; asynchronous, active-low
- region_pal  in  1  1 = PAL geometry; sampled only at frame start
- render_en  in  1  background_EN | sprite_EN
- nmi_en  in  1  control-register NMI enable
- status_rd  in  1  single-CLK pulse: CPU read of status register
- dot_ce  out  1  one-CLK pulse per dot
- dot  out  CNT_W  current dot 0..DOTS_PER_LINE-1
- line  out  CNT_W  current scanline; last line = pre-render
- visible  out  1  line < 240
- prerender  out  1  line == last line of current mode
- vblank  out  1  vblank flag (status bit 7)
- set_vblank  out  1  one-CLK pulse when flag is set
- clear_vblank  out  1  one-CLK pulse at pre-render dot 1
- nmi_n  out  1  active-low NMI = !(vblank & nmi_en)
- frame_odd  out  1  toggles each frame
- region_q  out  1  latched region in effect

## Operation
- Divider: counts 0..DIV-1 (DIV per region_q). dot_ce=1 in the CLK where the count is DIV-1; the count then returns to 0.
- On dot_ce, dot increments. At dot 340 it wraps to 0 and line increments. At last line, dot 340, line wraps to 0, frame_odd toggles and region_q <= region_pal.
- Odd-frame skip: NTSC only (region_q=0). When render_en=1 and frame_odd=1 at pre-render dot 339, the next dot is line 0 dot 0, so dot 340 is skipped. frame_odd toggles and region is latched exactly as on a normal wrap. render_en is sampled at the dot_ce of dot 339.
- vblank set: on the dot_ce that enters line VBLANK_LINE dot 1, with a set_vblank pulse on the same CLK.
- vblank clear: on the dot_ce that enters pre-render dot 1, with a clear_vblank pulse. Also cleared the CLK after any status_rd.
- Read race: if status_rd arrives in the dot period whose dot_ce would set vblank (line VBLANK_LINE dot 0), the set is suppressed for that frame. set_vblank is still not pulsed and no NMI occurs.
- nmi_n is combinational on registered vblank and nmi_en. Raising nmi_en while vblank=1 asserts NMI immediately; this is the required behaviour.
- Widths: all compares are against parameters of width CNT_W. Counters never exceed 340 / LINES-1.

## Timing
- Reset values (async, RST=0): divider 0, dot 0, line 0, vblank 0, frame_odd 0, region_q 0 (NTSC). dot_ce, set_vblank and clear_vblank are 0; nmi_n 1.
- First dot_ce: DIV_NTSC CLKs after RST deasserts.
- dot/line/vblank update in the same CLK as dot_ce; consumers sample them on the next dot_ce.
- Reset mid-frame: counters return to 0 immediately; no pulses are emitted during reset.
- A region_pal change mid-frame has no effect until the next wrap; the divider modulus changes only at that wrap.
- status_rd and a clear at the same CLK: vblank 0, single clear_vblank pulse.

## Structure
- Package ppu_timing_pkg holds the default geometry constants, region encoding and a dot/line struct typedef.
- Sub-module ppu_dot_divider: modulus-select counter producing dot_ce, taking DIV_NTSC/DIV_PAL and region_q.
- The rest lives in a single always_ff plus combinational qualifiers.

## Test plan
- Reset: hold RST=0, toggle CLK -> all outputs at reset values; release -> dot_ce on CLK 4, then every 4.
- NTSC even frame, render_en=0: count dot_ce between line-0 dot-0 events -> 89342; vblank high for 20×341 dots.
- NTSC with render_en=1: odd frame -> 89341 dots and dot 340 never observed on pre-render; even frame -> 89342.
- vblank/NMI: nmi_en=1 -> nmi_n falls at line 241 dot 1. status_rd -> vblank 0 and nmi_n 1 the next CLK. nmi_en toggled 0->1 mid-vblank -> nmi_n reasserts.
- Race: status_rd during line 241 dot 0 -> no set_vblank, vblank stays 0 for that frame, nmi_n stays 1.
- PAL: set region_pal=1 mid-frame -> NTSC timing until wrap, then dot_ce every 5 CLKs, 312 lines, no odd skip; frame = 106392 dots = 531960 CLKs.
